stream_patchifier: RTL and testbench
====================================

STREAM_PATCHIFIER -- requirements
Module: stream_patchifier

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, default 8, meaning bits per colour channel.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, meaning channels per pixel; PIXEL_WIDTH = CHANNEL_SIZE*NUM_CHANNELS.
REQ-003 SHALL have parameters IMG_WIDTH and IMG_HEIGHT, default 16 each, meaning image size in pixels; both are multiples of PATCH_SIZE.
REQ-004 SHALL have parameter PATCH_SIZE, default 4, meaning patch edge, a power of two >= 2.
REQ-005 SHALL derive NUM_PATCHES = (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE) and PATCH_VEC = PATCH_SIZE*PATCH_SIZE.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 synchronous, active-high reset.
REQ-007 SHALL have ports: in_valid in 1, in_ready out 1, in_pixel in PIXEL_WIDTH, in_sof in 1 (first raster pixel of a frame).
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_pixel out PIXEL_WIDTH, out_last_patch out 1 (last element of a patch), out_last_frame out 1 (last element of a frame).
REQ-009 SHALL have ports: frame_err out 1 (one-cycle pulse on misaligned in_sof).
REQ-010 SHALL have, only when PATCHIFIER_IDX_OUT_EN is defined: out_patch_idx out $clog2(NUM_PATCHES), out_pos_idx out $clog2(PATCH_VEC).

Function
REQ-011 SHALL accept one pixel per cycle when in_valid && in_ready, raster order, row 0 column 0 first.
REQ-012 SHALL buffer pixels in two strip banks, each PATCH_SIZE rows x IMG_WIDTH pixels, filled and drained in ping-pong order.
REQ-013 SHALL drive in_ready = 1 when the bank being filled is not full; in_ready = 0 when both banks are full.
REQ-014 SHALL mark a bank full on the edge accepting its last pixel (strip row PATCH_SIZE-1, column IMG_WIDTH-1).
REQ-015 SHALL emit a full strip's patches left to right, each patch's PATCH_VEC elements row-major within the patch.
REQ-016 SHALL make patch_idx = strip*(IMG_WIDTH/PATCH_SIZE)+patch column and pos_idx = row_in_patch*PATCH_SIZE+col_in_patch.
REQ-017 SHALL assert out_valid first on the cycle after the bank-full edge (latency 1 cycle from last strip pixel accepted).
REQ-018 SHALL hold out_pixel, indices and flags stable while out_valid && !out_ready; advance one element per out_valid && out_ready.
REQ-019 SHALL free a bank on the handshake of its last element; with the other bank full, out_valid stays 1 with no bubble.
REQ-020 SHALL handle fill-complete and drain-complete on the same edge independently; neither event lost.
REQ-021 SHALL assert out_last_patch when pos_idx = PATCH_VEC-1; out_last_frame when also patch_idx = NUM_PATCHES-1.
REQ-022 SHALL wrap input and output counters to 0 after the last frame element, with no idle cycle between frames.
REQ-023 SHALL, on accepted in_sof with input counter != 0: pulse frame_err next cycle, drop the partial strip, store the pixel as row 0 column 0.
REQ-024 SHALL ignore in_sof when the input counter is 0 (no error); frames with in_sof never asserted are accepted.

Reset
REQ-025 SHALL on reset clear both banks' full flags, all counters, out_valid=0, frame_err=0, out_last_patch=0, out_last_frame=0; in_ready=1 first cycle after reset.
REQ-026 SHALL, on reset mid-frame, discard all buffered data; no stale element emitted after reset.
REQ-027 SHALL not require bank memory contents to be cleared by reset.

Configuration
REQ-028 SHALL with PATCHIFIER_IDX_OUT_EN defined expose out_patch_idx/out_pos_idx per REQ-016, stable under REQ-018.
REQ-029 SHALL with PATCHIFIER_IDX_OUT_EN undefined omit those ports; all other behaviour is identical.

Verification (IMG 8x8, PATCH_SIZE 4, 3x8-bit; pixel value = raster index)
REQ-030 SHALL cover: reset, stream 64 pixels, out_ready=1 -> first out_valid 1 cycle after pixel 31; first patch 0,1,2,3,8,9,10,11,16,..,27; out_last_frame on pixel 63.
REQ-031 SHALL cover: out_ready=0 throughout, in_valid=1 -> in_ready falls after pixel 63 accepted (both banks full); out_pixel holds 0.
REQ-032 SHALL cover: random out_ready/in_valid over 3 back-to-back frames -> 192 elements, exact order, no duplication, no loss.
REQ-033 SHALL cover: in_sof on pixel 10 of a frame -> frame_err pulses once; next output patch starts with the in_sof pixel.
REQ-034 SHALL cover: reset after 40 pixels with output stalled -> out_valid=0, in_ready=1; new frame outputs only new data.
REQ-035 SHALL cover: PATCHIFIER_IDX_OUT_EN defined -> element 17 reports patch_idx=1, pos_idx=1.

Source files
------------

// File: rtl/stream_patchifier.sv
// rtl/stream_patchifier.sv - raster pixel stream to patch-ordered stream converter
//
// Pixels arrive in raster order. They are written into two strip banks, each
// PATCH_SIZE rows by IMG_WIDTH pixels, which are used in ping-pong order.
// A full bank is drained patch by patch, left to right. Within a patch the
// elements leave in row-major order.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready/in_pixel  input pixel handshake
//   in_sof                      marks the first raster pixel of a frame
//   out_valid/out_ready         output element handshake
//   out_pixel                   output element
//   out_last_patch              set on the last element of a patch
//   out_last_frame              set on the last element of a frame
//   frame_err                   one-cycle pulse after a misaligned in_sof
//   out_patch_idx, out_pos_idx  element indices, present only when
//                               PATCHIFIER_IDX_OUT_EN is defined
`timescale 1ns/1ps

module stream_patchifier #(
  parameter int CHANNEL_SIZE = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int IMG_WIDTH    = 16,
  parameter int IMG_HEIGHT   = 16,
  parameter int PATCH_SIZE   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CHANNEL_SIZE*NUM_CHANNELS-1:0] in_pixel,
  input  logic                                 in_sof,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CHANNEL_SIZE*NUM_CHANNELS-1:0] out_pixel,
  output logic                                 out_last_patch,
  output logic                                 out_last_frame,
  output logic                                 frame_err
`ifdef PATCHIFIER_IDX_OUT_EN
  ,
  output logic [$clog2((IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE))-1:0] out_patch_idx,
  output logic [$clog2(PATCH_SIZE*PATCH_SIZE)-1:0]                          out_pos_idx
`endif
);

  localparam int PIXEL_WIDTH = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int NPC         = IMG_WIDTH / PATCH_SIZE;   // patches per strip
  localparam int NSTRIP      = IMG_HEIGHT / PATCH_SIZE;  // strips per frame
  localparam int NUM_PATCHES = NPC * NSTRIP;
  localparam int PATCH_VEC   = PATCH_SIZE * PATCH_SIZE;
  localparam int PB          = $clog2(PATCH_SIZE);
  localparam int PCW         = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int SW          = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;
  localparam int PIW         = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1;
  localparam int POW         = 2 * PB;

  localparam logic [PB-1:0]  PS_LAST  = PB'(PATCH_SIZE - 1);
  localparam logic [PCW-1:0] PC_LAST  = PCW'(NPC - 1);
  localparam logic [SW-1:0]  S_LAST   = SW'(NSTRIP - 1);
  localparam logic [POW-1:0] POS_LAST = POW'(PATCH_VEC - 1);
  localparam logic [PIW-1:0] PAT_LAST = PIW'(NUM_PATCHES - 1);

  // The column is split into (patch column, column within patch) so the
  // drain side can address a patch without a multiply.
  logic [PIXEL_WIDTH-1:0] bank_mem [2][PATCH_SIZE][NPC][PATCH_SIZE];

  logic [1:0]         full_q, full_d;
  logic               fill_bank_q, fill_bank_d;
  logic               drain_bank_q, drain_bank_d;
  logic [1:0][SW-1:0] bank_strip_q, bank_strip_d;
  logic [PB-1:0]      in_c_q, in_c_d;
  logic [PCW-1:0]     in_pcol_q, in_pcol_d;
  logic [PB-1:0]      in_row_q, in_row_d;
  logic [SW-1:0]      in_strip_q, in_strip_d;
  logic [PB-1:0]      o_c_q, o_c_d;
  logic [PB-1:0]      o_r_q, o_r_d;
  logic [PCW-1:0]     o_pcol_q, o_pcol_d;
  logic               frame_err_q, frame_err_d;

  logic               in_accept, sof_err, strip_done, out_hs, drain_done;
  logic [PB-1:0]      wr_c, wr_row;
  logic [PCW-1:0]     wr_pcol;
  logic [SW-1:0]      wr_strip;
  logic [PIW-1:0]     patch_idx_w;
  logic [POW-1:0]     pos_idx_w;

  assign in_ready  = !full_q[fill_bank_q];
  assign out_valid = full_q[drain_bank_q];
  assign frame_err = frame_err_q;
  assign out_pixel = bank_mem[drain_bank_q][o_r_q][o_pcol_q][o_c_q];

  // The strip number is latched per bank at fill time, so a frame restart
  // cannot mislabel a strip that is already waiting to drain.
  assign patch_idx_w    = PIW'(int'(bank_strip_q[drain_bank_q]) * NPC + int'(o_pcol_q));
  assign pos_idx_w      = {o_r_q, o_c_q};
  assign out_last_patch = out_valid && (pos_idx_w == POS_LAST);
  assign out_last_frame = out_last_patch && (patch_idx_w == PAT_LAST);

`ifdef PATCHIFIER_IDX_OUT_EN
  assign out_patch_idx = patch_idx_w;
  assign out_pos_idx   = pos_idx_w;
`endif

  always_comb begin
    full_d       = full_q;
    fill_bank_d  = fill_bank_q;
    drain_bank_d = drain_bank_q;
    bank_strip_d = bank_strip_q;
    in_c_d       = in_c_q;
    in_pcol_d    = in_pcol_q;
    in_row_d     = in_row_q;
    in_strip_d   = in_strip_q;
    o_c_d        = o_c_q;
    o_r_d        = o_r_q;
    o_pcol_d     = o_pcol_q;

    in_accept = in_valid && in_ready;
    sof_err   = in_accept && in_sof &&
                ((in_c_q != '0) || (in_pcol_q != '0) || (in_row_q != '0) || (in_strip_q != '0));
    frame_err_d = sof_err;

    // A misaligned start of frame abandons the partial strip and restarts
    // the write position at the bank origin, keeping the same fill bank.
    wr_c     = sof_err ? '0 : in_c_q;
    wr_pcol  = sof_err ? '0 : in_pcol_q;
    wr_row   = sof_err ? '0 : in_row_q;
    wr_strip = sof_err ? '0 : in_strip_q;

    strip_done = in_accept && (wr_c == PS_LAST) && (wr_pcol == PC_LAST) && (wr_row == PS_LAST);

    if (in_accept) begin
      in_c_d     = wr_c;
      in_pcol_d  = wr_pcol;
      in_row_d   = wr_row;
      in_strip_d = wr_strip;
      if (wr_c == PS_LAST) begin
        in_c_d = '0;
        if (wr_pcol == PC_LAST) begin
          in_pcol_d = '0;
          if (wr_row == PS_LAST) begin
            in_row_d   = '0;
            in_strip_d = (wr_strip == S_LAST) ? '0 : wr_strip + 1'b1;
          end else begin
            in_row_d = wr_row + 1'b1;
          end
        end else begin
          in_pcol_d = wr_pcol + 1'b1;
        end
      end else begin
        in_c_d = wr_c + 1'b1;
      end
    end

    // Fill and drain always touch different banks (the fill bank is not
    // full, the drain bank is), so both updates can land on one edge.
    if (strip_done) begin
      full_d[fill_bank_q]       = 1'b1;
      bank_strip_d[fill_bank_q] = wr_strip;
      fill_bank_d               = !fill_bank_q;
    end

    out_hs     = out_valid && out_ready;
    drain_done = out_hs && (o_c_q == PS_LAST) && (o_r_q == PS_LAST) && (o_pcol_q == PC_LAST);

    if (out_hs) begin
      if (o_c_q == PS_LAST) begin
        o_c_d = '0;
        if (o_r_q == PS_LAST) begin
          o_r_d    = '0;
          o_pcol_d = (o_pcol_q == PC_LAST) ? '0 : o_pcol_q + 1'b1;
        end else begin
          o_r_d = o_r_q + 1'b1;
        end
      end else begin
        o_c_d = o_c_q + 1'b1;
      end
    end

    if (drain_done) begin
      full_d[drain_bank_q] = 1'b0;
      drain_bank_d         = !drain_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q       <= '0;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      bank_strip_q <= '0;
      in_c_q       <= '0;
      in_pcol_q    <= '0;
      in_row_q     <= '0;
      in_strip_q   <= '0;
      o_c_q        <= '0;
      o_r_q        <= '0;
      o_pcol_q     <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      full_q       <= full_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      bank_strip_q <= bank_strip_d;
      in_c_q       <= in_c_d;
      in_pcol_q    <= in_pcol_d;
      in_row_q     <= in_row_d;
      in_strip_q   <= in_strip_d;
      o_c_q        <= o_c_d;
      o_r_q        <= o_r_d;
      o_pcol_q     <= o_pcol_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Bank storage needs no reset: only the full flags decide what is emitted.
  always_ff @(posedge clk) begin
    if (in_accept) begin
      bank_mem[fill_bank_q][wr_row][wr_pcol][wr_c] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_stream_patchifier.sv
// tb/tb_stream_patchifier.sv - self-checking bench for stream_patchifier (8x8 image, 4x4 patches)
`timescale 1ns/1ps

module tb_stream_patchifier;

  localparam int CS    = 8;
  localparam int NC    = 3;
  localparam int IW    = 8;
  localparam int IH    = 8;
  localparam int PS    = 4;
  localparam int PW    = CS * NC;
  localparam int NP    = (IW / PS) * (IH / PS);
  localparam int PV    = PS * PS;
  localparam int STRIP = PS * IW;
  localparam int FRAME = IW * IH;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sof;
  logic [PW-1:0] in_pixel;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_pixel;
  logic          out_last_patch, out_last_frame, frame_err;
`ifdef PATCHIFIER_IDX_OUT_EN
  logic [1:0]    out_patch_idx;
  logic [3:0]    out_pos_idx;
`endif

  stream_patchifier #(
    .CHANNEL_SIZE(CS), .NUM_CHANNELS(NC), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .PATCH_SIZE(PS)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last_patch(out_last_patch), .out_last_frame(out_last_frame),
    .frame_err(frame_err)
`ifdef PATCHIFIER_IDX_OUT_EN
    , .out_patch_idx(out_patch_idx), .out_pos_idx(out_pos_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int pix; bit lp; bit lf; int pidx; int pos; } elem_t;
  typedef struct { int idx; int pix; bit lf; } vec_t;

  elem_t exp_q[$];
  int    strip_buf[STRIP];
  int    cnt;
  bit    exp_err;
  int    got_pix[$];
  bit    got_lf[$];
`ifdef PATCHIFIER_IDX_OUT_EN
  int    got_pidx[$];
  int    got_pos[$];
`endif
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    first_ov;
  int    err_pulses;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: collect a strip in raster order, then emit it as patches.
  task automatic model_accept(input int pix, input bit sof);
    int    s;
    elem_t e;
    if (sof && cnt != 0) begin
      exp_err = 1'b1;
      cnt = 0;
    end
    strip_buf[cnt % STRIP] = pix;
    cnt++;
    if (cnt % STRIP == 0) begin
      s = cnt / STRIP - 1;
      for (int p = 0; p < IW / PS; p++)
        for (int r = 0; r < PS; r++)
          for (int c = 0; c < PS; c++) begin
            e.pix  = strip_buf[r * IW + p * PS + c];
            e.pidx = s * (IW / PS) + p;
            e.pos  = r * PS + c;
            e.lp   = (e.pos == PV - 1);
            e.lf   = e.lp && (e.pidx == NP - 1);
            exp_q.push_back(e);
          end
    end
    if (cnt == FRAME) cnt = 0;
  endtask

  task automatic check_outputs();
    cmp("frame_err", 64'(frame_err), 64'(exp_err));
    cmp("in_ready", 64'(in_ready), 64'(exp_q.size() <= STRIP));
    cmp("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0) begin
      cmp("out_pixel", 64'(out_pixel), 64'(exp_q[0].pix));
      cmp("out_last_patch", 64'(out_last_patch), 64'(exp_q[0].lp));
      cmp("out_last_frame", 64'(out_last_frame), 64'(exp_q[0].lf));
`ifdef PATCHIFIER_IDX_OUT_EN
      cmp("out_patch_idx", 64'(out_patch_idx), 64'(exp_q[0].pidx));
      cmp("out_pos_idx", 64'(out_pos_idx), 64'(exp_q[0].pos));
`endif
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit iv, input bit sof, input int pix, input bit ordy, output bit acc);
    check_outputs();
    if (frame_err) err_pulses++;
    if (out_valid && first_ov < 0) first_ov = cyc;
    in_valid  = iv;
    in_sof    = sof;
    in_pixel  = PW'(pix);
    out_ready = ordy;
    acc       = iv && in_ready;
    exp_err   = 1'b0;
    if (out_valid && ordy) begin
      got_pix.push_back(int'(out_pixel));
      got_lf.push_back(out_last_frame);
`ifdef PATCHIFIER_IDX_OUT_EN
      got_pidx.push_back(int'(out_patch_idx));
      got_pos.push_back(int'(out_pos_idx));
`endif
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (acc) model_accept(pix, sof);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0; in_pixel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); cnt = 0; exp_err = 1'b0;
    got_pix.delete(); got_lf.delete();
`ifdef PATCHIFIER_IDX_OUT_EN
    got_pidx.delete(); got_pos.delete();
`endif
    first_ov = -1; err_pulses = 0; cyc = 0;
    cmp("rst_out_valid", 64'(out_valid), 64'(0));
    cmp("rst_in_ready", 64'(in_ready), 64'(1));
    cmp("rst_frame_err", 64'(frame_err), 64'(0));
    cmp("rst_last_patch", 64'(out_last_patch), 64'(0));
    cmp("rst_last_frame", 64'(out_last_frame), 64'(0));
  endtask

  task automatic drain(input string name, input int bound);
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1'b0, 1'b0, 0, 1'b1, acc);
      n++;
    end
    cmp(name, 64'(exp_q.size()), 64'(0));
    repeat (2) step(1'b0, 1'b0, 0, 1'b1, acc);
  endtask

  initial begin
    vec_t tv[12];
    bit   acc;
    int   p, n, c0, acc31, stale;

    tv[0]  = '{0, 0, 1'b0};   tv[1]  = '{1, 1, 1'b0};   tv[2]  = '{3, 3, 1'b0};
    tv[3]  = '{4, 8, 1'b0};   tv[4]  = '{7, 11, 1'b0};  tv[5]  = '{12, 24, 1'b0};
    tv[6]  = '{15, 27, 1'b0}; tv[7]  = '{16, 4, 1'b0};  tv[8]  = '{31, 31, 1'b0};
    tv[9]  = '{32, 32, 1'b0}; tv[10] = '{48, 36, 1'b0}; tv[11] = '{63, 63, 1'b1};

    // Full frame, output always ready: latency and patch ordering.
    do_reset();
    p = 0; n = 0; acc31 = -1;
    while (p < FRAME && n < 500) begin
      c0 = cyc;
      step(1'b1, p == 0, p, 1'b1, acc);
      if (acc && p == 31) acc31 = c0;
      if (acc) p++;
      n++;
    end
    cmp("t1_fed", 64'(p), 64'(FRAME));
    drain("t1_drain", 200);
    cmp("t1_latency", 64'(first_ov), 64'(acc31 + 1));
    cmp("t1_count", 64'(got_pix.size()), 64'(FRAME));
    for (int i = 0; i < 12; i++) begin
      if (tv[i].idx < got_pix.size()) begin
        cmp("t1_vec_pix", 64'(got_pix[tv[i].idx]), 64'(tv[i].pix));
        cmp("t1_vec_last_frame", 64'(got_lf[tv[i].idx]), 64'(tv[i].lf));
      end else begin
        cmp("t1_vec_present", 64'(got_pix.size()), 64'(tv[i].idx + 1));
      end
    end
`ifdef PATCHIFIER_IDX_OUT_EN
    if (got_pidx.size() > 17) begin
      cmp("t1_elem17_patch_idx", 64'(got_pidx[17]), 64'(1));
      cmp("t1_elem17_pos_idx", 64'(got_pos[17]), 64'(1));
    end else begin
      cmp("t1_elem17_present", 64'(got_pidx.size()), 64'(18));
    end
`endif

    // Output stalled: both banks fill, then input back-pressures.
    do_reset();
    p = 0; n = 0;
    while (p < FRAME && n < 300) begin
      step(1'b1, p == 0, p, 1'b0, acc);
      if (acc) p++;
      n++;
    end
    cmp("t2_fed", 64'(p), 64'(FRAME));
    cmp("t2_in_ready_low", 64'(in_ready), 64'(0));
    cmp("t2_out_valid", 64'(out_valid), 64'(1));
    cmp("t2_out_pixel", 64'(out_pixel), 64'(0));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, FRAME, 1'b0, acc);
      cmp("t2_blocked", 64'(acc), 64'(0));
    end
    cmp("t2_hold_pixel", 64'(out_pixel), 64'(0));
    drain("t2_drain", 300);
    cmp("t2_count", 64'(got_pix.size()), 64'(FRAME));

    // Three back-to-back frames with random handshakes on both sides.
    do_reset();
    p = 0; n = 0;
    while ((p < 3 * FRAME || exp_q.size() != 0) && n < 5000) begin
      step((p < 3 * FRAME) && ($urandom_range(0, 3) != 0), (p % FRAME) == 0, p,
           $urandom_range(0, 2) != 0, acc);
      if (acc) p++;
      n++;
    end
    cmp("t3_fed", 64'(p), 64'(3 * FRAME));
    cmp("t3_left", 64'(exp_q.size()), 64'(0));
    cmp("t3_count", 64'(got_pix.size()), 64'(3 * FRAME));

    // Misaligned start of frame on pixel 10.
    do_reset();
    p = 0; n = 0;
    while (p < 10 + FRAME && n < 500) begin
      step(1'b1, (p == 0) || (p == 10), p, 1'b1, acc);
      if (acc) p++;
      n++;
    end
    cmp("t4_fed", 64'(p), 64'(10 + FRAME));
    drain("t4_drain", 200);
    cmp("t4_err_pulses", 64'(err_pulses), 64'(1));
    cmp("t4_count", 64'(got_pix.size()), 64'(FRAME));
    if (got_pix.size() != 0) cmp("t4_first", 64'(got_pix[0]), 64'(10));
    else cmp("t4_first_present", 64'(got_pix.size()), 64'(1));

    // Reset mid-frame with data buffered; only new data may come out.
    do_reset();
    p = 0;
    while (p < 40) begin
      step(1'b1, p == 0, p, 1'b0, acc);
      if (acc) p++;
    end
    do_reset();
    p = 0; n = 0;
    while (p < FRAME && n < 500) begin
      step(1'b1, p == 0, 1000 + p, 1'b1, acc);
      if (acc) p++;
      n++;
    end
    drain("t5_drain", 200);
    cmp("t5_count", 64'(got_pix.size()), 64'(FRAME));
    stale = 0;
    foreach (got_pix[i]) if (got_pix[i] < 1000) stale++;
    cmp("t5_stale", 64'(stale), 64'(0));
    if (got_pix.size() != 0) cmp("t5_first", 64'(got_pix[0]), 64'(1000));
    else cmp("t5_first_present", 64'(got_pix.size()), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
